fip_post_acc: RTL

//  Post-multiply end of the fast-inner-product datapath. Consumes the signed

---
 rtl/fip_post_acc.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fip_post_acc.sv
// Post-multiply accumulator: sums (prod - corr) over LEN beats, emits one result per block.
// Define FIP_POST_ACC_SATURATE_EN to clip the result to OUT_W and report it on sat_o.
module fip_post_acc #(
  parameter int IN_SIZE_1 = 8,
  parameter int LEN       = 16,
  parameter int OUT_W     = 32,
  localparam int PROD_W   = 2 * (IN_SIZE_1 + 1),
  localparam int ACC_W    = PROD_W + 1 + $clog2(LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PROD_W-1:0] prod_i,
  input  logic [PROD_W-1:0] corr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OUT_W-1:0]  out_o,
  output logic              sat_o
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {ACC, OUT} state_t;

  state_t                    state_reg, state_next;
  logic signed [ACC_W-1:0]   acc_reg;
  logic        [CNT_W-1:0]   cnt_reg;
  logic        [OUT_W-1:0]   out_reg;
  logic signed [ACC_W-1:0]   prod_ext, corr_ext, sum_next;
  logic        [OUT_W-1:0]   res;
  logic                      res_sat;
  logic                      beat, last_beat;

  assign in_ready_o  = (state_reg == ACC);
  assign out_valid_o = (state_reg == OUT);
  assign beat        = in_valid_i && in_ready_o;
  assign last_beat   = (cnt_reg == CNT_W'(LEN - 1));

  assign prod_ext = {{(ACC_W - PROD_W){prod_i[PROD_W-1]}}, prod_i};
  assign corr_ext = {{(ACC_W - PROD_W){corr_i[PROD_W-1]}}, corr_i};
  assign sum_next = acc_reg + prod_ext - corr_ext;

  // Narrowing the ACC_W sum to OUT_W: either saturate or wrap.
  generate
    if (OUT_W >= ACC_W) begin : g_wide
      assign res     = OUT_W'(sum_next);
      assign res_sat = 1'b0;
    end else begin : g_narrow
`ifdef FIP_POST_ACC_SATURATE_EN
      logic over_pos, over_neg;
      assign over_pos = !sum_next[ACC_W-1] && (|sum_next[ACC_W-2:OUT_W-1]);
      assign over_neg =  sum_next[ACC_W-1] && !(&sum_next[ACC_W-2:OUT_W-1]);
      always_comb begin
        res     = sum_next[OUT_W-1:0];
        res_sat = 1'b0;
        if (over_pos) begin
          res     = {1'b0, {(OUT_W-1){1'b1}}};
          res_sat = 1'b1;
        end else if (over_neg) begin
          res     = {1'b1, {(OUT_W-1){1'b0}}};
          res_sat = 1'b1;
        end
      end
`else
      assign res     = sum_next[OUT_W-1:0];
      assign res_sat = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACC: if (beat && last_beat) state_next = OUT;
      OUT: if (out_ready_i) state_next = ACC;
      default: state_next = ACC;
    endcase
    // Abort wins over any beat or handshake in the same cycle.
    if (clr_i) state_next = ACC;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ACC;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (clr_i) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (beat) begin
        if (last_beat) begin
          acc_reg <= '0;
          cnt_reg <= '0;
          out_reg <= res;
        end else begin
          acc_reg <= sum_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign out_o = out_reg;

`ifdef FIP_POST_ACC_SATURATE_EN
  logic sat_reg;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_reg <= 1'b0;
    end else if (!clr_i && beat && last_beat) begin
      sat_reg <= res_sat;
    end
  end
  assign sat_o = sat_reg;
`else
  assign sat_o = 1'b0;
`endif

endmodule
